ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares the single-port image/filter RAM between the DMA block, which writes decompressed row blocks and CPU words, and the CNN engine, which reads operands. Each requester receives bursts of up to MAX_BURST beats in round-robin order. The block multiplexes address, write data and control onto the RAM port and returns a read-valid strobe to the CNN side. It sits between the DMA block, the CNN datapath and the RAM.

## Interface
- ADDR_W, 16, RAM address width
- DATA_W, 4, RAM word width (equals DMA blockSize)
- MAX_BURST, 4, max beats per grant; ≥1
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- dma_req  in  1  DMA requests the port; one beat per cycle while req && gnt
- dma_last  in  1  marks final beat of a DMA burst
- dma_addr  in  ADDR_W  DMA write address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA owns the port
- cnn_req  in  1  CNN requests the port
- cnn_last  in  1  marks final beat of a CNN burst
- cnn_addr  in  ADDR_W  CNN read address
- cnn_gnt  out  1  CNN owns the port
- cnn_rvalid  out  1  cnn_rdata holds data for the CNN beat of the previous cycle
- cnn_rdata  out  DATA_W  passthrough of ram_rdata
- ram_rdata  in  DATA_W  RAM read data, one cycle after address
- ram_enable  out  1  RAM access this cycle
- ram_write  out  1  1 = write, 0 = read
- ram_address  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data

## Operation
- FSM states: IDLE, DMA_OWN, CNN_OWN. dma_gnt = (state==DMA_OWN) and cnn_gnt = (state==CNN_OWN), both decoded from registered state.
- Reset values: state IDLE, beat_cnt 0, last_owner = CNN (DMA wins the first contention), cnn_rvalid 0, both grants 0, ram_enable 0, ram_write 0.
- A beat is a cycle with the owner's req high. ram_enable = beat. ram_write = beat && DMA_OWN. ram_address and ram_wdata are muxed from the owner and are 0 in IDLE. ram_wdata is 0 during CNN beats.
- IDLE at posedge:
  - both reqs → grant !last_owner
  - one req → grant it
  - none → stay IDLE.
- On entering an OWN state: beat_cnt ← 0, last_owner ← new owner.
- In an OWN state, each beat does beat_cnt+1. The burst ends at the posedge where any of these holds:
  - a beat with last=1
  - a beat with beat_cnt == MAX_BURST−1
  - owner req low (release, no beat).
- At burst end, the next state is the other requester's OWN state if its req is high at that edge, otherwise IDLE. The former owner is never regranted directly and must re-arbitrate from IDLE. Handover to a waiting requester costs no idle cycle.
- Read return: cnn_rvalid ← (beat && CNN_OWN) at each posedge. cnn_rdata = ram_rdata combinationally.
- beat_cnt width is clog2(MAX_BURST)+1 and never wraps. It is cleared on every grant.
- Reset mid-burst clears the state asynchronously. ram_enable and ram_write drop immediately. A read in flight produces no cnn_rvalid.

## Timing
- Grant latency from IDLE: req high before posedge k → gnt high after k → first beat in cycle k.
- Throughput: one beat per cycle while the owner keeps req high. Max hold is MAX_BURST cycles.
- Handover: a burst ending at edge e with the other requester waiting → the other requester's gnt is high in the cycle after e.
- cnn_rvalid rises exactly one cycle after each CNN beat, including the beat after handover to DMA.
- Requesters must hold addr/data stable in beat cycles. Input last is ignored when req is low.

## Test plan
- Reset: assert rst=0 mid CNN_OWN → gnts, ram_enable, ram_write, cnn_rvalid all 0 immediately. Release → IDLE.
- Single DMA burst: dma_req 3 cycles, addr 0x10..0x12, wdata 1,2,3, last on beat 3 → three writes at those addresses, dma_gnt deasserts after the third beat, state IDLE.
- Burst cap: cnn_req held 6 cycles, no last, MAX_BURST=4 → 4 reads, cnn_rvalid on 4 consecutive cycles one cycle late, gnt drops, IDLE for 1 cycle, then regrant.
- Contention from reset: both reqs rise together → DMA granted first. At DMA burst end CNN is granted with zero idle cycles. Next contention from IDLE → DMA again (last_owner=CNN).
- Handover mid-burst: CNN bursting with dma_req waiting and cnn_last on beat 2 → dma_gnt high the next cycle. cnn_rvalid for beat 2 coincides with the first DMA write.
- Release without last: owner drops req for one cycle → burst ends at that edge with no RAM access that cycle. The other requester is granted if pending, otherwise IDLE.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundles the DMA, CNN and RAM-side signals of the shared image/filter RAM port.
// The arbiter connects through the slave modport; the requesters and RAM use master.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 4
);
  logic              dma_req;
  logic              dma_last;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              cnn_req;
  logic              cnn_last;
  logic [ADDR_W-1:0] cnn_addr;
  logic              cnn_gnt;
  logic              cnn_rvalid;
  logic [DATA_W-1:0] cnn_rdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_enable;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_wdata;

  modport slave (
    input  dma_req, dma_last, dma_addr, dma_wdata,
    input  cnn_req, cnn_last, cnn_addr, ram_rdata,
    output dma_gnt, cnn_gnt, cnn_rvalid, cnn_rdata,
    output ram_enable, ram_write, ram_address, ram_wdata
  );

  modport master (
    output dma_req, dma_last, dma_addr, dma_wdata,
    output cnn_req, cnn_last, cnn_addr, ram_rdata,
    input  dma_gnt, cnn_gnt, cnn_rvalid, cnn_rdata,
    input  ram_enable, ram_write, ram_address, ram_wdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin burst arbiter sharing one single-port RAM between DMA writes and CNN reads.
// Bursts end on last, on the beat cap, or when the owner drops req; handover costs no idle cycle.
module ram_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_arbiter_if.slave     bus
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DMA_OWN = 2'd1,
    CNN_OWN = 2'd2
  } state_t;

  state_t            state_r;
  state_t            next_s;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic              last_dma_r;   // 1: DMA held the most recent grant
  logic              cnn_rvalid_r;

  logic              owner_req_s;
  logic              owner_last_s;
  logic              beat_s;
  logic              burst_end_s;
  logic              grant_s;
  logic              ram_write_s;
  logic [ADDR_W-1:0] ram_address_s;
  logic [DATA_W-1:0] ram_wdata_s;

  // Owner request/last selection and burst-termination decode
  always_comb begin
    owner_req_s  = 1'b0;
    owner_last_s = 1'b0;
    case (state_r)
      DMA_OWN: begin
        owner_req_s  = bus.dma_req;
        owner_last_s = bus.dma_last;
      end
      CNN_OWN: begin
        owner_req_s  = bus.cnn_req;
        owner_last_s = bus.cnn_last;
      end
      default: begin
        owner_req_s  = 1'b0;
        owner_last_s = 1'b0;
      end
    endcase
    beat_s      = owner_req_s;
    burst_end_s = (state_r != IDLE) &&
                  (!owner_req_s || owner_last_s || (beat_cnt_r == CNT_CAP));
  end

  // Next-state logic: round-robin from IDLE, direct handover at burst end
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.dma_req && bus.cnn_req) begin
          next_s = last_dma_r ? CNN_OWN : DMA_OWN;
        end else if (bus.dma_req) begin
          next_s = DMA_OWN;
        end else if (bus.cnn_req) begin
          next_s = CNN_OWN;
        end else begin
          next_s = IDLE;
        end
      end
      DMA_OWN: begin
        if (burst_end_s) begin
          next_s = bus.cnn_req ? CNN_OWN : IDLE;
        end else begin
          next_s = DMA_OWN;
        end
      end
      CNN_OWN: begin
        if (burst_end_s) begin
          next_s = bus.dma_req ? DMA_OWN : IDLE;
        end else begin
          next_s = CNN_OWN;
        end
      end
      default: next_s = IDLE;
    endcase
    grant_s = (next_s != state_r) && (next_s != IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Beat counter, round-robin memory and read-return strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_r   <= '0;
      last_dma_r   <= 1'b0;
      cnn_rvalid_r <= 1'b0;
    end else begin
      cnn_rvalid_r <= beat_s && (state_r == CNN_OWN);
      if (grant_s) begin
        beat_cnt_r <= '0;
        last_dma_r <= (next_s == DMA_OWN);
      end else if (beat_s) begin
        beat_cnt_r <= beat_cnt_r + 1'b1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

  // RAM port multiplexing from the current owner
  always_comb begin
    ram_write_s   = 1'b0;
    ram_address_s = '0;
    ram_wdata_s   = '0;
    case (state_r)
      DMA_OWN: begin
        ram_write_s   = beat_s;
        ram_address_s = bus.dma_addr;
        ram_wdata_s   = bus.dma_wdata;
      end
      CNN_OWN: begin
        ram_write_s   = 1'b0;
        ram_address_s = bus.cnn_addr;
        ram_wdata_s   = '0;
      end
      default: begin
        ram_write_s   = 1'b0;
        ram_address_s = '0;
        ram_wdata_s   = '0;
      end
    endcase
  end

  assign bus.dma_gnt     = (state_r == DMA_OWN);
  assign bus.cnn_gnt     = (state_r == CNN_OWN);
  assign bus.ram_enable  = beat_s;
  assign bus.ram_write   = ram_write_s;
  assign bus.ram_address = ram_address_s;
  assign bus.ram_wdata   = ram_wdata_s;
  assign bus.cnn_rvalid  = cnn_rvalid_r;
  assign bus.cnn_rdata   = bus.ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a transaction-level owner/burst model predicts
// per-cycle port activity and read returns; a monitor compares against the DUT.
module tb_ram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 4;
  localparam int MB = 4;

  typedef struct {
    int            cyc;
    logic          dg;
    logic          cg;
    logic          en;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } cyc_rec_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rv_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port RAM with one-cycle read latency
  logic [DW-1:0] ram_mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (bus.ram_enable) begin
      if (bus.ram_write) ram_mem[bus.ram_address[7:0]] <= bus.ram_wdata;
      else               bus.ram_rdata <= ram_mem[bus.ram_address[7:0]];
    end
  end

  // Reference model: who owns the port, beats taken in this burst, who was served last
  int            m_owner = 0;   // 0 none, 1 DMA, 2 CNN
  int            m_beats = 0;
  int            m_last  = 2;
  logic [DW-1:0] m_mem [256] = '{default: '0};

  cyc_rec_t cq[$];
  rv_rec_t  rq[$];
  int cyc_cnt  = 0;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
  endtask

  task automatic model_step();
    cyc_rec_t r;
    rv_rec_t  v;
    bit oreq, olast, other;
    int nxt;
    r.cyc = cyc_cnt;
    if (!rst) begin
      r.dg = 1'b0; r.cg = 1'b0; r.en = 1'b0; r.wr = 1'b0; r.addr = '0; r.wd = '0;
      cq.push_back(r);
      m_owner = 0; m_beats = 0; m_last = 2;
      return;
    end
    oreq  = (m_owner == 1) ? bus.dma_req  : (m_owner == 2) ? bus.cnn_req  : 1'b0;
    olast = (m_owner == 1) ? bus.dma_last : (m_owner == 2) ? bus.cnn_last : 1'b0;
    other = (m_owner == 1) ? bus.cnn_req  : (m_owner == 2) ? bus.dma_req  : 1'b0;
    r.dg   = (m_owner == 1);
    r.cg   = (m_owner == 2);
    r.en   = oreq;
    r.wr   = oreq && (m_owner == 1);
    r.addr = (m_owner == 1) ? bus.dma_addr : (m_owner == 2) ? bus.cnn_addr : '0;
    r.wd   = (m_owner == 1) ? bus.dma_wdata : '0;
    cq.push_back(r);
    if (oreq) begin
      m_beats++;
      if (m_owner == 1) begin
        m_mem[bus.dma_addr[7:0]] = bus.dma_wdata;
      end else begin
        v.cyc  = cyc_cnt + 1;
        v.data = m_mem[bus.cnn_addr[7:0]];
        rq.push_back(v);
      end
    end
    nxt = m_owner;
    if (m_owner == 0) begin
      if (bus.dma_req && bus.cnn_req) nxt = (m_last == 2) ? 1 : 2;
      else if (bus.dma_req)           nxt = 1;
      else if (bus.cnn_req)           nxt = 2;
    end else if (!oreq || olast || m_beats == MB) begin
      nxt = other ? (3 - m_owner) : 0;
    end
    if (nxt != 0 && nxt != m_owner) begin
      m_beats = 0;
      m_last  = nxt;
    end
    m_owner = nxt;
  endtask

  task automatic cycle(input bit r, input bit dq, input bit dl, input logic [AW-1:0] da,
                       input logic [DW-1:0] dw, input bit cr, input bit cl,
                       input logic [AW-1:0] ca);
    @(negedge clk);
    rst          = r;
    bus.dma_req  = dq;
    bus.dma_last = dl;
    bus.dma_addr = da;
    bus.dma_wdata = dw;
    bus.cnn_req  = cr;
    bus.cnn_last = cl;
    bus.cnn_addr = ca;
    cyc_cnt++;
    #1;
    model_step();
  endtask

  // Monitor: one port record per cycle, one read-return record per cnn_rvalid
  always begin
    cyc_rec_t r;
    rv_rec_t  v;
    @(negedge clk);
    #2;
    if (cq.size() > 0) begin
      r = cq.pop_front();
      chk("dma_gnt",     bus.dma_gnt,     r.dg);
      chk("cnn_gnt",     bus.cnn_gnt,     r.cg);
      chk("ram_enable",  bus.ram_enable,  r.en);
      chk("ram_write",   bus.ram_write,   r.wr);
      chk("ram_address", bus.ram_address, r.addr);
      chk("ram_wdata",   bus.ram_wdata,   r.wd);
    end
    if (rq.size() > 0 && rq[0].cyc == cyc_cnt) begin
      v = rq.pop_front();
      chk("cnn_rvalid", bus.cnn_rvalid, 1'b1);
      if (bus.cnn_rvalid) chk("cnn_rdata", bus.cnn_rdata, v.data);
    end else begin
      chk("cnn_rvalid_spurious", bus.cnn_rvalid, 1'b0);
    end
  end

  initial begin
    bus.dma_req = 1'b0; bus.dma_last = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.cnn_req = 1'b0; bus.cnn_last = 1'b0; bus.cnn_addr = '0;

    repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0);

    // Single DMA burst of three writes ending on last
    cycle(1'b1, 1'b1, 1'b0, 16'h10, 4'd1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 16'h10, 4'd1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 16'h11, 4'd2, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b1, 16'h12, 4'd3, 1'b0, 1'b0, 16'h0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0);

    // CNN request held past the beat cap, then released without last
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 16'h10 + 16'(i % 3));
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0);

    // Contention and mid-burst handovers in both directions
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 1'b1, (i == 2), 16'h20 + 16'(i), 4'(i), 1'b1, (i == 5), 16'h20 + 16'(i));
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0);

    // Asynchronous reset in the middle of a CNN burst
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 16'h11);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_dma_gnt",    bus.dma_gnt,    1'b0);
    chk("rst_cnn_gnt",    bus.cnn_gnt,    1'b0);
    chk("rst_ram_enable", bus.ram_enable, 1'b0);
    chk("rst_ram_write",  bus.ram_write,  1'b0);
    chk("rst_cnn_rvalid", bus.cnn_rvalid, 1'b0);
    rq.delete();
    m_owner = 0; m_beats = 0; m_last = 2;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 16'h11);
    cycle(1'b1, 1'b1, 1'b0, 16'h3, 4'h5, 1'b1, 1'b0, 16'h11);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'b1, ($urandom_range(0, 99) < 60), ($urandom_range(0, 3) == 0),
            16'($urandom_range(0, 15)), 4'($urandom),
            ($urandom_range(0, 99) < 60), ($urandom_range(0, 3) == 0),
            16'($urandom_range(0, 15)));

    repeat (3) cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    #3;
    chk("rvalid_queue_drained", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
